// File: rtl/cpu_trace_monitor.sv
// rtl/cpu_trace_monitor.sv - CPU debug-port observer: counters, MISR signature of ALU results, halt detect.
// Optional TRACE_MON_EXPECT_EN adds exp_sig compare with pass/fail flags on halt.

module trace_misr_step (
    input  logic [31:0] sig,
    input  logic [31:0] din,
    output logic [31:0] sig_nxt
);
    assign sig_nxt = {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ din;
endmodule

module cpu_trace_monitor #(
    parameter int HALT_CYCLES = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [31:0]      pc,
    input  logic [31:0]      f,
    input  logic [31:0]      mem,
    input  logic             zf,
    input  logic             of,
    input  logic             has_hazard,
`ifdef TRACE_MON_EXPECT_EN
    input  logic [31:0]      exp_sig,
    output logic             pass,
    output logic             fail,
`endif
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] zf_cnt,
    output logic             of_seen,
    output logic [31:0]      sig
);
    localparam int SC_W = $clog2(HALT_CYCLES) + 1;
    localparam logic [SC_W-1:0] HALT_LAST = SC_W'(HALT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t          state, state_nxt;
    logic [31:0]     pc_q;
    logic [SC_W-1:0] same_cnt;
    logic            first;
    logic            start, sample, pc_same;
    logic [31:0]     misr_nxt;
    logic            mem_unused;

    // Memory data is part of the observed bus but deliberately not hashed.
    assign mem_unused = ^mem;

    trace_misr_step u_misr (
        .sig     (sig),
        .din     (f),
        .sig_nxt (misr_nxt)
    );

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
    endfunction

    assign pc_same = (pc == pc_q);
    assign running = (state == RUN);
    assign halted  = (state == HALTED);

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        sample    = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = RUN;
                    start     = 1'b1;
                end
            end
            RUN: begin
                // Dropping en beats a coincident halt: no sample is taken on that edge.
                if (!en) begin
                    state_nxt = IDLE;
                end else begin
                    sample = 1'b1;
                    if (!has_hazard && !first && pc_same && (same_cnt == HALT_LAST))
                        state_nxt = HALTED;
                end
            end
            HALTED: begin
                if (!en)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc_q      <= '0;
            same_cnt  <= '0;
            first     <= 1'b1;
            cycle_cnt <= '0;
            stall_cnt <= '0;
            zf_cnt    <= '0;
            of_seen   <= 1'b0;
            sig       <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                same_cnt  <= '0;
                first     <= 1'b1;
                cycle_cnt <= '0;
                stall_cnt <= '0;
                zf_cnt    <= '0;
                of_seen   <= 1'b0;
                sig       <= '0;
            end
            if (sample) begin
                cycle_cnt <= sat_inc(cycle_cnt, 1'b1);
                pc_q      <= pc;
                first     <= 1'b0;
                if (has_hazard) begin
                    stall_cnt <= sat_inc(stall_cnt, 1'b1);
                    same_cnt  <= '0;
                end else begin
                    sig     <= misr_nxt;
                    zf_cnt  <= sat_inc(zf_cnt, zf);
                    of_seen <= of_seen | of;
                    if (!first) begin
                        if (!pc_same)
                            same_cnt <= '0;
                        else if (same_cnt != {SC_W{1'b1}})
                            same_cnt <= same_cnt + SC_W'(1);
                    end
                end
            end
        end
    end

`ifdef TRACE_MON_EXPECT_EN
    // Compare against the signature that includes the halting sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass <= 1'b0;
            fail <= 1'b0;
        end else if (state == RUN && state_nxt == HALTED) begin
            pass <= (misr_nxt == exp_sig);
            fail <= (misr_nxt != exp_sig);
        end else if (state == HALTED && !en) begin
            pass <= 1'b0;
            fail <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// tb/tb_cpu_trace_monitor.sv - directed vector bench for cpu_trace_monitor.

module tb_cpu_trace_monitor;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] f = '0;
    logic [31:0] mem = '0;
    logic        zf = 1'b0;
    logic        of = 1'b0;
    logic        has_hazard = 1'b0;

    logic        running, halted, of_seen;
    logic [31:0] cycle_cnt, stall_cnt, zf_cnt, sig;
    logic        running4, halted4, of_seen4;
    logic [3:0]  cycle_cnt4, stall_cnt4, zf_cnt4;
    logic [31:0] sig4;
`ifdef TRACE_MON_EXPECT_EN
    logic [31:0] exp_sig = '0;
    logic        pass, fail, pass4, fail4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_trace_monitor #(.HALT_CYCLES(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .en(en), .pc(pc), .f(f), .mem(mem),
        .zf(zf), .of(of), .has_hazard(has_hazard),
`ifdef TRACE_MON_EXPECT_EN
        .exp_sig(exp_sig), .pass(pass), .fail(fail),
`endif
        .running(running), .halted(halted), .cycle_cnt(cycle_cnt),
        .stall_cnt(stall_cnt), .zf_cnt(zf_cnt), .of_seen(of_seen), .sig(sig)
    );

    cpu_trace_monitor #(.HALT_CYCLES(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .pc(pc), .f(f), .mem(mem),
        .zf(zf), .of(of), .has_hazard(has_hazard),
`ifdef TRACE_MON_EXPECT_EN
        .exp_sig(exp_sig), .pass(pass4), .fail(fail4),
`endif
        .running(running4), .halted(halted4), .cycle_cnt(cycle_cnt4),
        .stall_cnt(stall_cnt4), .zf_cnt(zf_cnt4), .of_seen(of_seen4), .sig(sig4)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic [31:0] pc;
        logic [31:0] f;
        logic        zf;
        logic        of;
        logic        hz;
        logic        running;
        logic        halted;
        logic [31:0] cyc;
        logic [31:0] stall;
        logic [31:0] zfc;
        logic        ofs;
        logic [31:0] sig;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic e, input logic [31:0] p, input logic [31:0] fv,
                                input logic z, input logic o, input logic h,
                                input logic run, input logic hal, input logic [31:0] c,
                                input logic [31:0] s, input logic [31:0] zc, input logic os,
                                input logic [31:0] sg);
        vec_t v;
        v.rst = r; v.en = e; v.pc = p; v.f = fv; v.zf = z; v.of = o; v.hz = h;
        v.running = run; v.halted = hal; v.cyc = c; v.stall = s; v.zfc = zc; v.ofs = os; v.sig = sg;
        return v;
    endfunction

    function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] d);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ d;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic [31:0] p, input logic [31:0] fv,
                       input logic z, input logic o, input logic h);
        rst = 1'b0; en = e; pc = p; f = fv; zf = z; of = o; has_hazard = h;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    vec_t vecs[17];
    logic [130:0] act_v, exp_v;
    logic [31:0] model;

    initial begin
        vecs[0]  = mk(1, 0, 32'h0,  32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[1]  = mk(0, 1, 32'h0,  32'h1,        0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0);
        vecs[2]  = mk(0, 1, 32'h0,  32'h1,        0, 0, 0, 1, 0, 1, 0, 0, 0, 32'h1);
        vecs[3]  = mk(0, 1, 32'h4,  32'h1,        0, 0, 0, 1, 0, 2, 0, 0, 0, 32'h2);
        vecs[4]  = mk(0, 1, 32'h8,  32'h1,        0, 0, 0, 1, 0, 3, 0, 0, 0, 32'h4);
        vecs[5]  = mk(0, 1, 32'h10, 32'hDEAD,     0, 0, 1, 1, 0, 4, 1, 0, 0, 32'h4);
        vecs[6]  = mk(0, 1, 32'h10, 32'hDEAD,     0, 0, 1, 1, 0, 5, 2, 0, 0, 32'h4);
        vecs[7]  = mk(1, 1, 32'h10, 32'hDEAD,     0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[8]  = mk(0, 0, 32'h10, 32'h1,        0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[9]  = mk(0, 0, 32'h14, 32'h1,        1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        vecs[10] = mk(0, 1, 32'h40, 32'h0,        0, 0, 0, 1, 0, 0, 0, 0, 0, 32'h0);
        vecs[11] = mk(0, 1, 32'h40, 32'h0,        1, 0, 0, 1, 0, 1, 0, 1, 0, 32'h0);
        vecs[12] = mk(0, 1, 32'h44, 32'h80000001, 1, 1, 1, 1, 0, 2, 1, 1, 0, 32'h0);
        vecs[13] = mk(0, 1, 32'h48, 32'h80000001, 0, 1, 0, 1, 0, 3, 1, 1, 1, 32'h80000001);
        vecs[14] = mk(0, 1, 32'h4C, 32'h0,        1, 0, 0, 1, 0, 4, 1, 2, 1, 32'h2);
        vecs[15] = mk(0, 0, 32'h50, 32'h7,        1, 1, 0, 0, 0, 4, 1, 2, 1, 32'h2);
        vecs[16] = mk(0, 0, 32'h54, 32'h7,        1, 1, 1, 0, 0, 4, 1, 2, 1, 32'h2);

        for (int i = 0; i < 17; i++) begin
            rst = vecs[i].rst; en = vecs[i].en; pc = vecs[i].pc; f = vecs[i].f;
            zf = vecs[i].zf; of = vecs[i].of; has_hazard = vecs[i].hz;
            @(posedge clk);
            #1;
            act_v = {running, halted, of_seen, cycle_cnt, stall_cnt, zf_cnt, sig};
            exp_v = {vecs[i].running, vecs[i].halted, vecs[i].ofs, vecs[i].cyc,
                     vecs[i].stall, vecs[i].zfc, vecs[i].sig};
            checks++;
            if (act_v !== exp_v) begin
                errors++;
                $display("FAIL vec%0d: got %h expected %h", i, act_v, exp_v);
            end
        end

        // Halt after 9 equal-PC samples; outputs frozen while halted.
        do_reset();
        cyc(1, 32'h0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 32'h20, 32'h0, 0, 0, 0);
        check("halt_8_samples", 32'(halted), 32'h0);
        cyc(1, 32'h20, 32'h0, 0, 0, 0);
        check("halt_9_samples", 32'(halted), 32'h1);
        check("halt_running", 32'(running), 32'h0);
        check("halt_cycle_cnt", cycle_cnt, 32'd9);
        cyc(1, 32'h30, 32'h5, 1, 1, 0);
        check("halted_frozen_cnt", cycle_cnt, 32'd9);
        check("halted_frozen_sig", sig, 32'h0);
        check("halted_frozen_zf", zf_cnt, 32'h0);
        cyc(0, 32'h30, 32'h5, 0, 0, 0);
        check("halted_to_idle", 32'({running, halted}), 32'h0);
        check("idle_keeps_cnt", cycle_cnt, 32'd9);

        // Hazard in the 5th sample restarts the equal-PC count.
        cyc(1, 32'h0, 32'h0, 0, 0, 0);
        for (int i = 1; i <= 12; i++) cyc(1, 32'h20, 32'h0, 0, 0, (i == 5));
        check("hz_restart_12", 32'(halted), 32'h0);
        check("hz_restart_stall", stall_cnt, 32'd1);
        cyc(1, 32'h20, 32'h0, 0, 0, 0);
        check("hz_restart_13", 32'(halted), 32'h1);

        // en falling on the would-be halting edge wins.
        cyc(0, 32'h20, 32'h0, 0, 0, 0);
        cyc(1, 32'h0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(1, 32'h20, 32'h0, 0, 0, 0);
        cyc(0, 32'h20, 32'h0, 0, 0, 0);
        check("en_fall_wins", 32'({running, halted}), 32'h0);
        check("en_fall_cnt", cycle_cnt, 32'd8);
        cyc(0, 32'h20, 32'h0, 0, 0, 0);
        check("en_fall_stays", 32'(halted), 32'h0);

        // Narrow counters saturate; of only counts in non-hazard cycles.
        do_reset();
        cyc(1, 32'h0, 32'h0, 0, 0, 0);
        cyc(1, 32'h0, 32'h0, 0, 1, 1);
        check("of_hazard_ignored", 32'(of_seen4), 32'h0);
        cyc(1, 32'h4, 32'h0, 0, 1, 0);
        check("of_seen_set", 32'(of_seen4), 32'h1);
        for (int i = 2; i < 20; i++) cyc(1, 32'(4 * (i + 1)), 32'h0, 0, 0, 0);
        check("cnt4_saturate", 32'(cycle_cnt4), 32'hF);
        check("cnt4_stall", 32'(stall_cnt4), 32'h1);
        check("cnt32_twenty", cycle_cnt, 32'd20);

`ifdef TRACE_MON_EXPECT_EN
        model = misr(misr(misr(32'h0, 32'h1), 32'h1), 32'h1);
        for (int i = 0; i < 8; i++) model = misr(model, 32'h0);
        for (int k = 0; k < 2; k++) begin
            do_reset();
            exp_sig = (k == 0) ? model : (model ^ 32'h1);
            cyc(1, 32'h0, 32'h0, 0, 0, 0);
            cyc(1, 32'h0, 32'h1, 0, 0, 0);
            cyc(1, 32'h4, 32'h1, 0, 0, 0);
            cyc(1, 32'h8, 32'h1, 0, 0, 0);
            for (int i = 0; i < 8; i++) cyc(1, 32'h8, 32'h0, 0, 0, 0);
            check("exp_halted", 32'(halted), 32'h1);
            check("exp_sig_model", sig, model);
            check("exp_pass_fail", 32'({pass, fail}), (k == 0) ? 32'h2 : 32'h1);
            cyc(0, 32'h8, 32'h0, 0, 0, 0);
            check("exp_clear", 32'({pass, fail}), 32'h0);
        end
`else
        model = '0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
